// File: rtl/hash_uart_tx.sv
// hash_uart_tx: sends a latched 160-bit digest as 40 lowercase ASCII hex
// characters (optionally followed by CR LF) over an 8N1 UART line.
// Each character k is taken from word k/8, most significant nibble first.
module hash_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SEND_CRLF    = 1
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic [159:0] hash,
    input  logic         start,
    output logic         UART_Tx,
    output logic         busy,
    output logic         done
);

    localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int N_BYTES = (SEND_CRLF != 0) ? 42 : 40;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0]        BYTE_LAST = 6'(N_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_nxt;
    logic [2:0]          w_bit_inc;
    logic [5:0]          r_byte;
    logic [5:0]          w_byte_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_load;
    logic [159:0]        r_hash;
    logic                w_baud_tc;
    logic [7:0]          w_cur_byte;

    // Nibble to lowercase ASCII hex digit.
    function automatic logic [7:0] f_hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h57 + {4'h0, nib};
        end
    endfunction

    // Message byte at position idx: hex digits of H_0..H_4, then CR, LF.
    function automatic logic [7:0] f_msg_byte(input logic [159:0] h, input logic [5:0] idx);
        logic [7:0] base;
        base = {idx[5:3], 5'd0} + {3'd0, 3'd7 - idx[2:0], 2'd0};
        if (idx == 6'd40) begin
            return 8'h0D;
        end else if (idx == 6'd41) begin
            return 8'h0A;
        end else begin
            return f_hex_ascii(h[base +: 4]);
        end
    endfunction

    assign w_baud_tc  = (r_baud == BAUD_LAST);
    assign w_bit_inc  = r_bit + 3'd1;
    assign w_cur_byte = f_msg_byte(r_hash, r_byte);

    assign UART_Tx = r_tx;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and line-level decisions for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_tx_nxt    = 1'b1;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start seen while done is still high waits one cycle, so
                // a held start never coincides with the done pulse.
                if (start && !r_done) begin
                    w_state_nxt = ST_START;
                    w_load      = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_byte_nxt  = 6'd0;
                end
            end
            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_tc) begin
                    w_state_nxt = ST_DATA;
                    w_baud_nxt  = '0;
                    w_tx_nxt    = w_cur_byte[0];
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                w_tx_nxt = w_cur_byte[r_bit];
                if (w_baud_tc) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_bit_nxt   = 3'd0;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = w_cur_byte[w_bit_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_tc) begin
                    w_state_nxt = ST_NEXT;
                    w_baud_nxt  = '0;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_NEXT: begin
                // Single idle-high cycle between frames.
                if (r_byte == BYTE_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_byte_nxt  = 6'd0;
                    w_done_nxt  = 1'b1;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_START;
                    w_byte_nxt  = r_byte + 6'd1;
                    w_tx_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Baud, bit and byte counters plus the registered line and done pulse.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_baud <= '0;
            r_bit  <= 3'd0;
            r_byte <= 6'd0;
            r_tx   <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_baud <= w_baud_nxt;
            r_bit  <= w_bit_nxt;
            r_byte <= w_byte_nxt;
            r_tx   <= w_tx_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Digest snapshot taken on the accepting edge; isolates the message from later hash changes.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_hash <= '0;
        end else if (w_load) begin
            r_hash <= hash;
        end
    end

endmodule

// File: tb/tb_hash_uart_tx.sv
// Bench for hash_uart_tx: a line decoder turns the serial output into bytes,
// which are compared with the hex text of the digest built by $sformatf.
module tb_hash_uart_tx;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB + 1;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b0;
    logic [159:0] hash_a  = '0;
    logic [159:0] hash_b  = '0;
    logic         start_a = 1'b0;
    logic         start_b = 1'b0;
    logic         tx_a, busy_a, done_a;
    logic         tx_b, busy_b, done_b;
    logic         sel = 1'b0;   // 0 watches the CRLF instance, 1 the plain one
    logic         w_line, w_busy, w_done;

    int           cyc = 0;
    int           n_err = 0;
    int           n_chk = 0;
    int           n_excl = 0;
    logic [7:0]   q_bytes[$];
    logic [7:0]   q_exp[$];
    int           q_fstart[$];
    int           q_done[$];

    hash_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hash(hash_a), .start(start_a),
        .UART_Tx(tx_a), .busy(busy_a), .done(done_a)
    );

    hash_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_CRLF(0)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hash(hash_b), .start(start_b),
        .UART_Tx(tx_b), .busy(busy_b), .done(done_b)
    );

    assign w_line = sel ? tx_b   : tx_a;
    assign w_busy = sel ? busy_b : busy_a;
    assign w_done = sel ? done_b : done_a;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected message text: the five words printed as hex, H_0 first.
    task automatic build_model(input logic [159:0] h, input bit crlf, input int reps);
        string s;
        q_exp.delete();
        s = $sformatf("%08h%08h%08h%08h%08h", h[31:0], h[63:32], h[95:64], h[127:96], h[159:128]);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < s.len(); i++) q_exp.push_back(s[i]);
            if (crlf) begin
                q_exp.push_back(8'h0D);
                q_exp.push_back(8'h0A);
            end
        end
    endtask

    task automatic check_bytes(input string tag);
        chk({tag, "_len"}, q_bytes.size(), q_exp.size());
        for (int i = 0; i < q_exp.size() && i < q_bytes.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), q_bytes[i], q_exp[i]);
    endtask

    task automatic clear_q();
        q_bytes.delete();
        q_fstart.delete();
        q_done.delete();
    endtask

    task automatic wait_bytes(input int n, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (q_bytes.size() >= n) break;
            @(negedge sys_clk);
        end
        chk(tag, q_bytes.size() >= n, 1);
    endtask

    // Waits for n done cycles; reports when the first is seen and how many
    // cycles busy was low while the message was still in flight.
    task automatic wait_done(input int n, input int max_cyc, input string tag,
                             output int t_done, output int busy_gap);
        int seen;
        seen = 0;
        busy_gap = 0;
        t_done = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge sys_clk);
            if (w_done === 1'b1) begin
                seen++;
                t_done = cyc;
            end else if (w_busy !== 1'b1) begin
                busy_gap++;
            end
            if (seen >= n) break;
        end
        chk(tag, seen >= n, 1);
    endtask

    // Line decoder: 40 samples per frame, each bit must hold for CPB cycles.
    initial begin : mon_line
        logic [39:0] smp;
        logic [7:0]  b;
        int          t0;
        bit          aborted;
        bit          ok;
        forever begin
            @(negedge sys_clk);
            if (sys_rst === 1'b1 && w_line === 1'b0) begin
                t0 = cyc;
                smp = '0;
                aborted = 1'b0;
                for (int i = 1; i < 40; i++) begin
                    @(negedge sys_clk);
                    if (sys_rst !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[i] = w_line;
                end
                if (!aborted) begin
                    ok = 1'b1;
                    for (int bt = 0; bt < 10; bt++)
                        for (int j = 1; j < CPB; j++)
                            if (smp[CPB*bt+j] !== smp[CPB*bt]) ok = 1'b0;
                    if (smp[9*CPB] !== 1'b1) ok = 1'b0;
                    for (int k = 0; k < 8; k++) b[k] = smp[CPB*(k+1)];
                    chk("frame_shape", ok, 1);
                    q_bytes.push_back(b);
                    q_fstart.push_back(t0);
                end
            end
        end
    end

    // Done pulse log and busy/done exclusivity watch.
    initial begin : mon_done
        forever begin
            @(negedge sys_clk);
            if (w_done === 1'b1) q_done.push_back(cyc);
            if (w_done === 1'b1 && w_busy === 1'b1) n_excl++;
        end
    end

    initial begin : stim
        logic [159:0] h;
        int acc, td1, td2, gap, lows;

        // Reset state
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;

        // Standard IV message
        hash_a = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
        build_model(hash_a, 1'b1, 1);
        clear_q();
        @(negedge sys_clk);
        start_a = 1'b1;
        @(posedge sys_clk);
        #1;
        acc = cyc;
        chk("iv_busy_after_accept", busy_a, 1);
        chk("iv_startbit_next_cycle", tx_a, 0);
        @(negedge sys_clk);
        start_a = 1'b0;
        wait_done(1, 2500, "iv_done_seen", td1, gap);
        chk("iv_done_latency", td1 - acc, 42 * FRAME_CYC);
        chk("iv_busy_held", gap, 0);
        repeat (60) @(negedge sys_clk);
        check_bytes("iv");
        if (q_bytes.size() > 0) chk("iv_first_char", q_bytes[0], 8'h36);
        if (q_fstart.size() > 1) begin
            chk("iv_first_frame_start", q_fstart[0], acc);
            chk("iv_frame_spacing", q_fstart[1] - q_fstart[0], FRAME_CYC);
        end
        chk("iv_done_once", q_done.size(), 1);
        chk("iv_idle_busy", busy_a, 0);

        // Random digest; change hash and re-pulse start mid-message
        h = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        hash_a = h;
        build_model(h, 1'b1, 1);
        clear_q();
        @(negedge sys_clk);
        start_a = 1'b1;
        @(negedge sys_clk);
        start_a = 1'b0;
        wait_bytes(10, 800, "ign_reach_byte10");
        hash_a = '1;
        @(negedge sys_clk);
        start_a = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("ign_busy_during_restart", busy_a, 1);
        @(negedge sys_clk);
        start_a = 1'b0;
        wait_done(1, 2500, "ign_done_seen", td1, gap);
        chk("ign_busy_held", gap, 0);
        repeat (150) @(negedge sys_clk);
        check_bytes("ign");
        chk("ign_done_once", q_done.size(), 1);

        // Reset in the middle of a frame
        hash_a = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        clear_q();
        @(negedge sys_clk);
        start_a = 1'b1;
        @(negedge sys_clk);
        start_a = 1'b0;
        wait_bytes(3, 400, "rmid_reach_byte3");
        for (int i = 0; i < 100; i++) begin
            if (tx_a === 1'b0) break;
            @(negedge sys_clk);
        end
        chk("rmid_line_low_found", tx_a, 0);
        #2;
        sys_rst = 1'b0;
        #1;
        chk("rmid_tx_async", tx_a, 1);
        chk("rmid_busy_async", busy_a, 0);
        chk("rmid_done_async", done_a, 0);
        repeat (4) @(negedge sys_clk);
        clear_q();
        sys_rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge sys_clk);
            if (tx_a !== 1'b1) lows++;
        end
        chk("rmid_line_stays_high", lows, 0);
        chk("rmid_no_done", q_done.size(), 0);
        chk("rmid_idle_busy", busy_a, 0);

        // Start held through reset release; hex digit boundaries
        @(negedge sys_clk);
        sys_rst = 1'b0;
        hash_a = {32'h9AF0F9A0, 32'hA9FA9F09, 32'h0F9A09AF, 32'hFA90AF90, 32'h09AF09AF};
        build_model(hash_a, 1'b1, 1);
        start_a = 1'b1;
        repeat (2) @(negedge sys_clk);
        clear_q();
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("rel_accept_busy", busy_a, 1);
        chk("rel_accept_startbit", tx_a, 0);
        @(negedge sys_clk);
        start_a = 1'b0;
        wait_done(1, 2500, "hex_done_seen", td1, gap);
        repeat (10) @(negedge sys_clk);
        check_bytes("hex");
        if (q_bytes.size() > 34) begin
            chk("hex_nib9", q_bytes[1], 8'h39);
            chk("hex_nib10", q_bytes[2], 8'h61);
            chk("hex_nib15", q_bytes[3], 8'h66);
            chk("hex_h4_nib9", q_bytes[32], 8'h39);
            chk("hex_h4_nib10", q_bytes[33], 8'h61);
            chk("hex_h4_nib15", q_bytes[34], 8'h66);
        end

        // Held start, no CRLF, zero digest: two back-to-back messages
        sel = 1'b1;
        hash_b = '0;
        build_model(hash_b, 1'b0, 2);
        clear_q();
        @(negedge sys_clk);
        start_b = 1'b1;
        @(posedge sys_clk);
        #1;
        acc = cyc;
        wait_done(1, 2500, "held_done1_seen", td1, gap);
        chk("held_msg1_latency", td1 - acc, 40 * FRAME_CYC);
        repeat (3) @(negedge sys_clk);
        start_b = 1'b0;
        wait_done(1, 2500, "held_done2_seen", td2, gap);
        chk("held_msg2_busy_held", gap, 0);
        repeat (150) @(negedge sys_clk);
        check_bytes("held");
        if (q_fstart.size() > 40) begin
            chk("held_msg2_start", q_fstart[40] - td1, 2);
            chk("held_msg2_latency", td2 - q_fstart[40], 40 * FRAME_CYC);
        end
        chk("held_done_twice", q_done.size(), 2);
        chk("busy_done_exclusive", n_excl, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hash_uart_tx.md
HASH_UART_TX -- requirements
Module: hash_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving sys_clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter SEND_CRLF, default 1; when 1, each message ends with 0x0D then 0x0A.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port hash, input, 160 bits: digest; H_0 = [31:0], H_1 = [63:32], H_2 = [95:64], H_3 = [127:96], H_4 = [159:128].
REQ-006 SHALL have port start, input, 1 bit: request to transmit the current hash; level-sampled in IDLE only.
REQ-007 SHALL have port UART_Tx, output, 1 bit: serial line, idle high, 8N1, LSB first.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until the cycle done pulses.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse after the last stop bit of the message.

Function
REQ-010 SHALL, on an accepted start (start=1 in IDLE), latch hash into an internal 160-bit register in the same edge; later hash changes SHALL NOT affect the message.
REQ-011 SHALL send 40 ASCII hex characters in order H_0..H_4, each word most-significant nibble first: character k uses hash[32*(k/8)+4*(7-k%8)+3 -: 4].
REQ-012 SHALL encode nibble 0-9 as 0x30-0x39 and nibble 10-15 as lowercase 0x61-0x66.
REQ-013 SHALL append 0x0D, 0x0A when SEND_CRLF=1, for 42 bytes per message; otherwise 40.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, NEXT:
- IDLE -> START on accepted start.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bit periods.
- STOP -> NEXT after CLKS_PER_BIT cycles.
- NEXT -> START if bytes remain, else -> IDLE with a done pulse.
REQ-015 SHALL make NEXT last exactly one cycle, so consecutive frames are separated by one sys_clk cycle of idle-high line.
REQ-016 SHALL drive UART_Tx:
- low for exactly CLKS_PER_BIT cycles in START;
- data bit i for CLKS_PER_BIT cycles in DATA, i = 0..7;
- high in STOP, NEXT and IDLE.
REQ-017 SHALL drive UART_Tx from a register, so the output is glitch-free; the start bit begins the cycle after start is accepted.
REQ-018 SHALL use a baud counter of width clog2(CLKS_PER_BIT), a 3-bit bit index, and a 6-bit byte index; each wraps to 0 at its terminal count.
REQ-019 SHALL ignore start while busy=1; no queuing, no restart.
REQ-020 SHALL, if start is held high continuously, begin a new message on the first IDLE cycle after done; done and the new accept SHALL NOT coincide.
REQ-021 SHALL assert busy and done mutually exclusively.

Reset
REQ-022 SHALL, while sys_rst=0, force: UART_Tx=1, busy=0, done=0, state=IDLE, all counters=0, latched hash=0, regardless of sys_clk.
REQ-023 SHALL, on reset mid-frame, return UART_Tx high immediately (asynchronously) and discard the message; no done pulse is generated.
REQ-024 SHALL accept start on the first rising edge after sys_rst deasserts.

Verification (CLKS_PER_BIT=4, SEND_CRLF=1 unless noted)
REQ-025 Reset check: hold sys_rst=0 mid-frame -> UART_Tx=1, busy=0, done=0 within the same cycle; after release, line stays high with start=0.
REQ-026 Standard IV: hash with H_0=0x67452301, H_1=0xEFCDAB89, H_2=0x98BADCFE, H_3=0x10325476, H_4=0xC3D2E1F0, pulse start ->
- decoded bytes "67452301efcdab8998badcfe10325476c3d2e1f0" then 0x0D, 0x0A;
- done pulses 42*(10*4+1) cycles after accept.
REQ-027 Frame timing: first byte '6' (0x36) -> line shows 0 start, bits 0,1,1,0,1,1,0,0, 1 stop, each exactly 4 cycles; line high for exactly 1 cycle before the next start bit.
REQ-028 Latch/ignore: change hash to all-ones and pulse start at byte 10 -> message unchanged, no second message, busy held high.
REQ-029 Held start with SEND_CRLF=0, hash=0 -> two back-to-back messages of 40 0x30 bytes each; done pulses once per message; start bit of message 2 begins 2 cycles after done.
REQ-030 Hex boundary: hash = 0x...09AF pattern on nibble 9/10 and 15 edges -> 0x39, 0x61, 0x66 emitted at the computed character positions.
